linebuf_multitap: RTL

Single-clock, parametrised multi-line ring buffer. It is the successor to the single-tap BRAM linebuffer and feeds vertical filters and scalers in the output pipeline. Incoming lines are written into a ring of NUM_LINES line slots. NUM_TAPS vertically adjacent lines are read in parallel at one x position, with explicit fill-level tracking, line-advance handshake and overflow/underflow detection.

---
 rtl/linebuf_pkg.sv | 27 ++
 rtl/linebuf_bank.sv | 34 +++
 rtl/linebuf_multitap.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/linebuf_pkg.sv
// linebuf_pkg: shared types, default geometry and helpers for the multi-tap line buffer.
// Contents: default parameter values, derived widths, FSM state enum, ring pointer add.
// Imported by linebuf_multitap and linebuf_bank.
package linebuf_pkg;

  localparam int LB_CH_WIDTH  = 8;
  localparam int LB_NUM_CH    = 3;
  localparam int LB_NUM_LINES = 8;
  localparam int LB_NUM_TAPS  = 2;
  localparam int LB_MAX_WIDTH = 2048;

  localparam int XW    = $clog2(LB_MAX_WIDTH);
  localparam int PIX_W = LB_NUM_CH * LB_CH_WIDTH;
  localparam int PTR_W = $clog2(LB_NUM_LINES);

  typedef enum logic [1:0] {
    LB_IDLE,
    LB_FILL,
    LB_RUN
  } lb_state_t;

  // Ring pointer add, wrapping at n line slots.
  function automatic int ptr_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/linebuf_bank.sv
// linebuf_bank: simple dual-port RAM, one write port, one read port with clock enable.
// Latency: read data registered, valid one cycle after rd_addr_i when rd_en_i is high.
// Ports: clk_i, rst_n_i, wr_en_i/wr_addr_i/wr_dat_i, rd_en_i/rd_addr_i, rd_dat_o.
module linebuf_bank
  import linebuf_pkg::*;
#(
  parameter int DAT_W = PIX_W,
  parameter int AW    = PTR_W + XW
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [DAT_W-1:0] wr_dat_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [DAT_W-1:0] rd_dat_o
);

  logic [DAT_W-1:0] mem [2**AW];
  logic [DAT_W-1:0] rd_dat_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     rd_dat_q <= '0;
    else if (rd_en_i) rd_dat_q <= mem[rd_addr_i];
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/linebuf_multitap.sv
// linebuf_multitap: ring of NUM_LINES line slots, NUM_TAPS adjacent lines read in parallel.
// Latency: taps_o/taps_valid_o 2 cycles after xpos_rd_i; lines_avail_o 1 cycle after count.
// Ports: pixel write (DE_i/datavalid_i/pix_i), tap read (xpos_rd_i/taps_o), line_adv_i release,
// sticky overflow_o/underflow_o. Optional macro LINEBUF_EDGE_REPLICATE_EN: valid from one
// committed line, missing taps replicate the newest line.
module linebuf_multitap
  import linebuf_pkg::*;
#(
  parameter int CH_WIDTH  = LB_CH_WIDTH,
  parameter int NUM_CH    = LB_NUM_CH,
  parameter int NUM_LINES = LB_NUM_LINES,
  parameter int NUM_TAPS  = LB_NUM_TAPS,
  parameter int MAX_WIDTH = LB_MAX_WIDTH
) (
  input  logic                                  PCLK_i,
  input  logic                                  reset_n,
  input  logic                                  enable_i,
  input  logic                                  frame_start_i,
  input  logic                                  DE_i,
  input  logic                                  datavalid_i,
  input  logic [NUM_CH*CH_WIDTH-1:0]            pix_i,
  input  logic [$clog2(MAX_WIDTH)-1:0]          xpos_rd_i,
  input  logic                                  line_adv_i,
  output logic [NUM_TAPS*NUM_CH*CH_WIDTH-1:0]   taps_o,
  output logic                                  taps_valid_o,
  output logic [$clog2(NUM_LINES):0]            lines_avail_o,
  output logic                                  overflow_o,
  output logic                                  underflow_o
);

  localparam int X_W      = $clog2(MAX_WIDTH);
  localparam int PIX_BITS = NUM_CH * CH_WIDTH;
  localparam int SLOT_W   = $clog2(NUM_LINES);
  localparam int CNT_W    = SLOT_W + 1;
  localparam int ADDR_W   = SLOT_W + X_W;

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(NUM_LINES);
  localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(NUM_TAPS);
  localparam logic [X_W:0]     WR_MAX = (X_W+1)'(MAX_WIDTH);

  lb_state_t         state_q, state_d;
  logic [SLOT_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, avail_q;
  // Pixels written into the open line; one extra bit so it saturates at MAX_WIDTH
  // and still distinguishes "last pixel written" from "empty line".
  logic [X_W:0]      wr_cnt_q, wr_cnt_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              de_prev_q, vld_p1_q, vld_p2_q;
  logic              flush, wr_en, commit, adv, adv_ok, run_vld;

  // Enabling out of IDLE restarts the ring exactly like a frame start.
  assign flush  = frame_start_i | (enable_i & (state_q == LB_IDLE));
  assign wr_en  = enable_i & ~flush & DE_i & datavalid_i & (wr_cnt_q < WR_MAX);
  assign commit = enable_i & de_prev_q & ~DE_i & (wr_cnt_q != '0);
  assign adv    = enable_i & line_adv_i;
  assign adv_ok = adv & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_cnt_d = wr_cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wr_cnt_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_en) wr_cnt_d = wr_cnt_q + (X_W+1)'(1);
      // Advance is judged against the pre-update count, even if a commit lands now.
      if (adv && !adv_ok) udf_d = 1'b1;
      if (commit) begin
        wr_ptr_d = SLOT_W'(ptr_add(int'(wr_ptr_q), 1, NUM_LINES));
        wr_cnt_d = '0;
        if (adv_ok) begin
          rd_ptr_d = SLOT_W'(ptr_add(int'(rd_ptr_q), 1, NUM_LINES));
        end else if (count_q == FULL_C) begin
          // Full ring: the new line overwrites the oldest one.
          ovf_d    = 1'b1;
          rd_ptr_d = SLOT_W'(ptr_add(int'(rd_ptr_q), 1, NUM_LINES));
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else if (adv_ok) begin
        rd_ptr_d = SLOT_W'(ptr_add(int'(rd_ptr_q), 1, NUM_LINES));
        count_d  = count_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i)              state_d = LB_IDLE;
    else if (count_d >= TAPS_C) state_d = LB_RUN;
    else                        state_d = LB_FILL;
  end

`ifdef LINEBUF_EDGE_REPLICATE_EN
  assign run_vld = (state_q != LB_IDLE) && (count_q != '0);
`else
  assign run_vld = (state_q == LB_RUN);
`endif

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LB_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      de_prev_q <= 1'b0;
      avail_q   <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_cnt_q  <= wr_cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      de_prev_q <= DE_i;
      avail_q   <= count_q;
      vld_p1_q  <= run_vld;
      vld_p2_q  <= vld_p1_q;
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    logic [SLOT_W-1:0]   slot;
    logic [ADDR_W-1:0]   addr_q;
    logic [PIX_BITS-1:0] dat;

`ifdef LINEBUF_EDGE_REPLICATE_EN
    // Taps beyond the committed lines repeat the newest line (top-edge replication).
    always_comb begin
      if ((CNT_W'(k) >= count_q) && (count_q != '0))
        slot = SLOT_W'(ptr_add(int'(rd_ptr_q), int'(count_q) - 1, NUM_LINES));
      else
        slot = SLOT_W'(ptr_add(int'(rd_ptr_q), k, NUM_LINES));
    end
`else
    assign slot = SLOT_W'(ptr_add(int'(rd_ptr_q), k, NUM_LINES));
`endif

    always_ff @(posedge PCLK_i or negedge reset_n) begin
      if (!reset_n) addr_q <= '0;
      else          addr_q <= {slot, xpos_rd_i};
    end

    linebuf_bank #(
      .DAT_W (PIX_BITS),
      .AW    (ADDR_W)
    ) u_bank (
      .clk_i     (PCLK_i),
      .rst_n_i   (reset_n),
      .wr_en_i   (wr_en),
      .wr_addr_i ({wr_ptr_q, wr_cnt_q[X_W-1:0]}),
      .wr_dat_i  (pix_i),
      .rd_en_i   (enable_i),
      .rd_addr_i (addr_q),
      .rd_dat_o  (dat)
    );

    // Tap 0 (oldest line) occupies the MSBs.
    assign taps_o[(NUM_TAPS-1-k)*PIX_BITS +: PIX_BITS] = dat;
  end

  assign taps_valid_o  = vld_p2_q;
  assign lines_avail_o = avail_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = udf_q;

endmodule
